// File: rtl/mul_unit.sv
// Sequential radix-2 shift-add multiplier: 32 CALC iterations plus one SIGN
// fix-up cycle, signed or unsigned operands, registered 2*WIDTH-bit product.
module mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mcand, mplier;
  logic [2*WIDTH-1:0] acc;
  logic [5:0]         count;
  logic               neg;
  logic               sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum;

  assign sa    = signed_mode & op_a[WIDTH-1];
  assign sb    = signed_mode & op_b[WIDTH-1];
  // -2^(WIDTH-1) negates to itself, which is already the correct magnitude
  assign mag_a = sa ? -op_a : op_a;
  assign mag_b = sb ? -op_b : op_b;
  assign sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
  assign busy  = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (count == LAST_ITER) state_nxt = SIGN;
      SIGN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      count     <= '0;
      neg       <= 1'b0;
      done      <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            neg    <= sa ^ sb;
            mcand  <= mag_a;
            mplier <= mag_b;
            acc    <= '0;
            count  <= '0;
          end
        end
        CALC: begin
          // carry lands in the top bit as the accumulator shifts right
          acc    <= {sum, acc[WIDTH-1:1]};
          mplier <= mplier >> 1;
          count  <= count + 6'd1;
        end
        SIGN: begin
          {result_hi, result_lo} <= neg ? -acc : acc;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed corner cases plus random operands
// compared against a plain 64-bit arithmetic reference.
module tb_mul_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        signed_mode;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] result_lo, result_hi;

  int checks = 0;
  int failures = 0;

  mul_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .signed_mode(signed_mode),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .result_lo(result_lo), .result_hi(result_hi)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sm);
    longint sa_v, sb_v;
    if (sm) begin
      sa_v = longint'($signed(a));
      sb_v = longint'($signed(b));
      return 64'(sa_v * sb_v);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Issues start at the next edge (edge N) and watches 36 cycles afterwards.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sm,
                        input bit repulse, input string tag);
    logic [63:0] exp;
    int busy_cnt, done_at, done_cnt;
    exp = model(a, b, sm);
    op_a = a; op_b = b; signed_mode = sm; start = 1'b1;
    tick();
    start = 1'b0;
    op_a = $urandom; op_b = $urandom; signed_mode = 1'($urandom);
    busy_cnt = 0; done_at = -1; done_cnt = 0;
    for (int c = 0; c < 36; c++) begin
      if (repulse && c == 4) begin
        start = 1'b1; op_a = 32'd2; op_b = 32'd2;
      end
      if (repulse && c == 5) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = c;
          check({tag, " result"}, {result_hi, result_lo}, exp);
          check({tag, " busy_in_done"}, 64'(busy), 64'd0);
        end
      end
      tick();
    end
    check({tag, " done_cycle"}, 64'(done_at), 64'd33);
    check({tag, " done_count"}, 64'(done_cnt), 64'd1);
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
    check({tag, " hold"}, {result_hi, result_lo}, exp);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; signed_mode = 1'b0; op_a = '0; op_b = '0;
    tick(); tick();
    reset = 1'b0;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset result", {result_hi, result_lo}, 64'd0);

    run_op(32'd7, 32'd6, 1'b0, 1'b0, "unsigned_small");
    check("unsigned_small lo", 64'(result_lo), 64'd42);
    run_op(32'hFFFFFFFD, 32'd5, 1'b1, 1'b0, "signed_mixed");
    check("signed_mixed value", {result_hi, result_lo}, 64'hFFFFFFFF_FFFFFFF1);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, "unsigned_max");
    check("unsigned_max value", {result_hi, result_lo}, 64'hFFFFFFFE_00000001);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, "signed_m1");
    check("signed_m1 value", {result_hi, result_lo}, 64'h1);
    run_op(32'h80000000, 32'h80000000, 1'b1, 1'b0, "signed_extreme");
    check("signed_extreme value", {result_hi, result_lo}, 64'h40000000_00000000);
    run_op(32'h80000000, 32'd3, 1'b1, 1'b0, "signed_min_pos");
    run_op(32'd0, 32'h12345678, 1'b1, 1'b0, "zero_a");
    run_op(32'h0000BEEF, 32'h00C0FFEE, 1'b0, 1'b1, "start_during_busy");

    // reset in the middle of an operation
    op_a = 32'd1000; op_b = 32'd1000; signed_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort result", {result_hi, result_lo}, 64'd0);
    tick();
    check("abort idle done", 64'(done), 64'd0);
    run_op(32'hFFFFFFF0, 32'd16, 1'b1, 1'b0, "after_abort");

    // reset wins over start on the same edge
    op_a = 32'd9; op_b = 32'd9; start = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    check("reset_vs_start busy", 64'(busy), 64'd0);
    check("reset_vs_start result", {result_hi, result_lo}, 64'd0);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra, rb;
      logic rs;
      ra = $urandom; rb = $urandom; rs = 1'($urandom);
      if (i % 6 == 1) ra = {1'b1, 31'($urandom_range(0, 3))};
      if (i % 6 == 2) rb = 32'($urandom_range(0, 2));
      run_op(ra, rb, rs, (i % 5 == 0), $sformatf("random%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
